activation_pipe: RTL and testbench

// - Multi-lane, two-stage pipelined activation unit for the vector datapath, placed between the MAC/accumulator output and writeback.
// - Applies one of four per-beat-selectable functions (bypass, ReLU, ReLU6, H-swish) to LANES signed fixed-point elements per beat.
// - Full valid/ready backpressure at one beat per cycle, with no bubbles.

---
 rtl/activation_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_activation_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_pipe.sv
// ---------------------------------------------------------------------------
// activation_pipe
//
// Purpose:
//   Two-stage pipelined, multi-lane activation unit that sits between the
//   MAC/accumulator output and writeback. Each beat carries LANES signed
//   Q(W-F).F elements. A 2-bit mode is sampled with the beat and selects the
//   function applied to every lane:
//     00 bypass (or leaky ReLU when ACT_LEAKY_EN is defined)
//     01 ReLU
//     10 ReLU6
//     11 H-swish
//   Valid/ready backpressure runs at one beat per cycle with no bubbles.
//
// Configuration macro:
//   ACT_LEAKY_EN  when defined, mode 00 is leaky ReLU with slope 1/8
//                 (x >>> 3 for negative x). When undefined, mode 00 is a
//                 plain bypass.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, flushes all beats
//   in_data    in   LANES*W, lane i = bits [i*W +: W]
//   in_mode    in   activation select, sampled with the beat
//   in_last    in   end-of-vector marker, carried with the beat
//   in_valid   in   beat offered
//   in_ready   out  beat accepted when in_valid && in_ready
//   out_data   out  LANES*W result beat
//   out_last   out  in_last of the same beat
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   downstream accept
//   busy       out  any beat held in either stage
// ---------------------------------------------------------------------------
module activation_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic [1:0]                  in_mode,
    input  logic                        in_last,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int W = DATA_WIDTH;
    localparam int F = FRAC_BITS;

    // Fixed-point constants: 3.0 in the widened S1 adder, 6.0 as the clamp
    // ceiling, and the saturation limits of a W-bit result held in 2W bits.
    localparam logic signed [W:0]     THREE_EXT = (W+1)'(3 << F);
    localparam logic signed [W:0]     SIX_EXT   = (W+1)'(6 << F);
    localparam logic signed [W-1:0]   SIX_W     = W'(6 << F);
    localparam logic signed [2*W-1:0] SIX_DIV   = (2*W)'(6);
    localparam logic signed [2*W-1:0] Y_MAX     = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] Y_MIN     = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_RELU   = 2'b01,
        MODE_RELU6  = 2'b10,
        MODE_HSWISH = 2'b11
    } mode_e;

    // Stage registers
    logic                 s1_valid_q, s1_valid_d;
    logic [LANES*W-1:0]   s1_x_q,     s1_x_d;
    logic [LANES*W-1:0]   s1_r6_q,    s1_r6_d;
    mode_e                s1_mode_q,  s1_mode_d;
    logic                 s1_last_q,  s1_last_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [LANES*W-1:0]   s2_data_q,  s2_data_d;
    logic                 s2_last_q,  s2_last_d;

    logic                 s1_ready;
    logic                 s2_ready;
    logic [LANES*W-1:0]   lane_r6;
    logic [LANES*W-1:0]   lane_y;

    // A stage can take a new beat when it is empty or its content leaves
    // this cycle, so both stages drain and refill in the same cycle.
    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;

    // Per-lane datapath: S1 front end computes clamp(x+3, 0, 6) so S2 only
    // has the multiply/divide of H-swish plus the simple mode functions.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [W-1:0]   x_in;
        logic signed [W:0]     t;
        logic signed [W-1:0]   r6_in;
        logic signed [W-1:0]   x_s1;
        logic signed [W-1:0]   r6_s1;
        logic signed [2*W-1:0] p;
        logic signed [2*W-1:0] s;
        logic signed [2*W-1:0] q;
        logic signed [W-1:0]   hswish;
        logic signed [W-1:0]   y;

        assign x_in = in_data[i*W +: W];
        // One extra bit keeps x + 3.0 from wrapping near the top of range.
        assign t    = {x_in[W-1], x_in} + THREE_EXT;

        always_comb begin
            r6_in = t[W-1:0];
            if (t[W]) begin
                r6_in = '0;
            end else if (t > SIX_EXT) begin
                r6_in = SIX_W;
            end
        end

        assign lane_r6[i*W +: W] = r6_in;

        assign x_s1  = s1_x_q[i*W +: W];
        assign r6_s1 = s1_r6_q[i*W +: W];
        assign p     = (2*W)'(x_s1) * (2*W)'(r6_s1);
        assign s     = p >>> F;
        // Signed division truncates toward zero, which is the required rounding.
        assign q     = s / SIX_DIV;

        always_comb begin
            hswish = q[W-1:0];
            if (q > Y_MAX) begin
                hswish = Y_MAX[W-1:0];
            end else if (q < Y_MIN) begin
                hswish = Y_MIN[W-1:0];
            end
        end

        always_comb begin
            y = x_s1;
            case (s1_mode_q)
                MODE_BYPASS: begin
`ifdef ACT_LEAKY_EN
                    y = x_s1[W-1] ? (x_s1 >>> 3) : x_s1;
`else
                    y = x_s1;
`endif
                end
                MODE_RELU:   y = x_s1[W-1] ? '0 : x_s1;
                MODE_RELU6:  y = x_s1[W-1] ? '0 : ((x_s1 > SIX_W) ? SIX_W : x_s1);
                MODE_HSWISH: y = hswish;
                default:     y = x_s1;
            endcase
        end

        assign lane_y[i*W +: W] = y;
    end

    // S1 next state: load on acceptance, empty when the beat moves on with
    // nothing behind it, otherwise hold.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_r6_d    = s1_r6_q;
        s1_mode_d  = s1_mode_q;
        s1_last_d  = s1_last_q;
        if (s1_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_x_d    = in_data;
                s1_r6_d   = lane_r6;
                s1_mode_d = mode_e'(in_mode);
                s1_last_d = in_last;
            end
        end
    end

    // S2 next state: output data only changes when S2 is free to advance,
    // which keeps out_data/out_last stable during a stall.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_last_d  = s2_last_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = lane_y;
                s2_last_d = s1_last_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_r6_q    <= '0;
            s1_mode_q  <= MODE_BYPASS;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_r6_q    <= s1_r6_d;
            s1_mode_q  <= s1_mode_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_last_q  <= s2_last_d;
        end
    end

    assign in_ready  = s1_ready;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_last  = s2_last_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_activation_pipe.sv
// ---------------------------------------------------------------------------
// tb_activation_pipe
//
// Self-checking bench for activation_pipe (W=16, F=8, LANES=4). Expected
// results come from an integer reference of the activation functions, and
// beats in flight are tracked as a queue of accepted-but-undelivered beats,
// each tagged with its acceptance cycle.
// ---------------------------------------------------------------------------
module tb_activation_pipe;

    localparam int W = 16;
    localparam int F = 8;
    localparam int L = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [L*W-1:0] in_data;
    logic [1:0]     in_mode;
    logic           in_last;
    logic           in_valid;
    logic           in_ready;
    logic [L*W-1:0] out_data;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    activation_pipe #(
        .DATA_WIDTH (W),
        .FRAC_BITS  (F),
        .LANES      (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [L*W-1:0] data;
        logic           last;
        int             acc_cycle;
    } beat_t;

    beat_t sb[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    cycle      = 0;
    int    delivered  = 0;

    // Reference activation for one lane, in plain integer arithmetic.
    function automatic logic [W-1:0] refLane(input logic [W-1:0] xb, input logic [1:0] mode);
        longint x;
        longint one;
        longint r6;
        longint s;
        longint y;
        one = longint'(1) << F;
        x   = $signed(xb);
        y   = x;
        case (mode)
            2'b00: begin
`ifdef ACT_LEAKY_EN
                if (x < 0) y = x >>> 3;
`endif
            end
            2'b01: y = (x < 0) ? 0 : x;
            2'b10: y = (x < 0) ? 0 : ((x > 6 * one) ? 6 * one : x);
            default: begin
                r6 = x + 3 * one;
                if (r6 < 0) r6 = 0;
                if (r6 > 6 * one) r6 = 6 * one;
                s = (x * r6) >>> F;
                y = s / 6;
                if (y > 32767) y = 32767;
                if (y < -32768) y = -32768;
            end
        endcase
        return y[W-1:0];
    endfunction

    function automatic logic [L*W-1:0] refBeat(input logic [L*W-1:0] d, input logic [1:0] mode);
        logic [L*W-1:0] r;
        r = '0;
        for (int i = 0; i < L; i++) r[i*W +: W] = refLane(d[i*W +: W], mode);
        return r;
    endfunction

    function automatic logic [L*W-1:0] randBeat();
        logic [L*W-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < L; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                r[i*W +: W] = W'($urandom);
            end else begin
                v = int'($urandom_range(0, 4095)) - 2048;
                r[i*W +: W] = W'(v);
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [L*W-1:0] d, input logic [1:0] m,
                                 input logic lst, input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        in_last   = lst;
        out_ready = rdy;
    endtask

    // One clock cycle: sample at the falling edge, compare against the
    // in-flight queue, then advance past the rising edge.
    task automatic stepCycle(output bit acc);
        bit dlv;
        bit exp_valid;
        acc = 1'b0;
        @(negedge clk);
        if (!rst) begin
            exp_valid = (sb.size() > 0) && (cycle - sb[0].acc_cycle >= 2);
            checkOutput("in_ready", 64'(in_ready), 64'((sb.size() < 2) || out_ready));
            checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
            checkOutput("busy", 64'(busy), 64'(sb.size() > 0));
            if (out_valid && sb.size() > 0) begin
                checkOutput("out_data", out_data, sb[0].data);
                checkOutput("out_last", 64'(out_last), 64'(sb[0].last));
            end
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            if (dlv && sb.size() > 0) begin
                void'(sb.pop_front());
                delivered++;
            end
            if (acc) sb.push_back('{data: refBeat(in_data, in_mode), last: in_last, acc_cycle: cycle});
        end
        @(posedge clk);
        #1;
        cycle++;
        if (rst) sb.delete();
    endtask

    initial begin
        bit             acc;
        int             sent;
        int             guard;
        int             start_deliv;
        logic [L*W-1:0] leaky_exp;

        rst = 1'b1;
        applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0);
        stepCycle(acc);
        stepCycle(acc);
        rst = 1'b0;

        // Reset state
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_data", out_data, 64'(0));
        checkOutput("rst_out_last", 64'(out_last), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));

        // H-swish directed beat with two-cycle latency
        applyStimulus(1'b1, 64'hFF00_0500_FC00_0100, 2'b11, 1'b1, 1'b1);
        stepCycle(acc);
        checkOutput("hswish_accept", 64'(acc), 64'(1));
        applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b1);
        stepCycle(acc);
        checkOutput("hswish_lat_valid", 64'(out_valid), 64'(1));
        checkOutput("hswish_data", out_data, 64'hFFAB_0500_0000_00AA);
        stepCycle(acc);

        // ReLU6 directed beat
        applyStimulus(1'b1, 64'h7FFF_0280_FF80_0700, 2'b10, 1'b0, 1'b1);
        stepCycle(acc);
        applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b1);
        stepCycle(acc);
        checkOutput("relu6_data", out_data, 64'h0600_0280_0000_0600);
        stepCycle(acc);

        // H-swish near top of range must not wrap on x+3
        applyStimulus(1'b1, 64'h0300_0000_8000_7F00, 2'b11, 1'b0, 1'b1);
        stepCycle(acc);
        applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b1);
        stepCycle(acc);
        checkOutput("hswish_nowrap", out_data, 64'h0300_0000_0000_7F00);
        stepCycle(acc);

        // Mode 00 on a negative lane
`ifdef ACT_LEAKY_EN
        leaky_exp = 64'hFFE0_FFE0_FFE0_FFE0;
`else
        leaky_exp = 64'hFF00_FF00_FF00_FF00;
`endif
        applyStimulus(1'b1, 64'hFF00_FF00_FF00_FF00, 2'b00, 1'b0, 1'b1);
        stepCycle(acc);
        applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b1);
        stepCycle(acc);
        checkOutput("mode00_data", out_data, leaky_exp);
        stepCycle(acc);

        // 16-beat stream, alternating modes, 5-cycle output stall mid-stream
        sent        = 0;
        guard       = 0;
        start_deliv = delivered;
        while ((sent < 16 || sb.size() > 0) && guard < 80) begin
            applyStimulus(sent < 16, randBeat(), 2'(sent % 4), (sent % 4 == 3),
                          !(guard >= 6 && guard < 11));
            if (guard == 10) checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
            stepCycle(acc);
            if (acc) sent++;
            guard++;
        end
        checkOutput("stream_deliv", 64'(delivered - start_deliv), 64'(16));
        checkOutput("stream_timeout", 64'(guard < 80), 64'(1));

        // Back-to-back input with out_ready high: no bubbles, busy falls after 2
        start_deliv = delivered;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, randBeat(), 2'($urandom_range(0, 3)), 1'($urandom), 1'b1);
            stepCycle(acc);
        end
        applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b1);
        checkOutput("tput_busy1", 64'(busy), 64'(1));
        stepCycle(acc);
        checkOutput("tput_busy2", 64'(busy), 64'(1));
        stepCycle(acc);
        checkOutput("tput_busy3", 64'(busy), 64'(0));
        checkOutput("tput_deliv", 64'(delivered - start_deliv), 64'(20));

        // Reset with both stages full: in-flight beats are discarded
        applyStimulus(1'b1, randBeat(), 2'b01, 1'b0, 1'b0);
        stepCycle(acc);
        applyStimulus(1'b1, randBeat(), 2'b11, 1'b1, 1'b0);
        stepCycle(acc);
        checkOutput("full_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        applyStimulus(1'b1, randBeat(), 2'b10, 1'b0, 1'b0);
        stepCycle(acc);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b1);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        checkOutput("midrst_in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 4; i++) stepCycle(acc);

        // Random traffic with random backpressure, then drain
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), randBeat(), 2'($urandom_range(0, 3)),
                          1'($urandom), 1'($urandom_range(0, 3) != 0));
            stepCycle(acc);
        end
        guard = 0;
        applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b1);
        while (sb.size() > 0 && guard < 20) begin
            stepCycle(acc);
            guard++;
        end
        checkOutput("drain_empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
